// File: rtl/sram_responder.sv
`timescale 1ns/1ps
`default_nettype none
// sram_responder: stand-in for the external 16-bit SRAM. It performs byte-masked
// writes into an internal array, returns pipelined read data on DQ, and counts accesses.
module sram_responder #(
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [15:0] SRAM_DQ,
  input  logic [17:0] SRAM_ADDR,
  input  logic        SRAM_LB_N,
  input  logic        SRAM_UB_N,
  input  logic        SRAM_WE_N,
  input  logic        SRAM_CE_N,
  input  logic        SRAM_OE_N,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count,
  output logic        proto_err
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LAST = READ_LAT - 1;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] idx;
    logic          lb_n;
    logic          ub_n;
  } rd_req_t;

  logic [15:0]   mem [DEPTH];

  rd_req_t       pipe_q [READ_LAT];
  rd_req_t       pipe_d [READ_LAT];
  logic          out_valid_q, out_valid_d;
  logic [15:0]   out_data_q, out_data_d;
  logic          out_lb_n_q, out_lb_n_d;
  logic          out_ub_n_q, out_ub_n_d;
  logic [15:0]   wr_count_q, wr_count_d;
  logic [15:0]   rd_count_q, rd_count_d;
  logic          proto_err_q, proto_err_d;

  logic [AW-1:0] idx;
  logic          is_write;
  logic          is_read;
  logic          drive_lo;
  logic          drive_hi;
  logic          unused_addr;

  assign idx         = SRAM_ADDR[AW-1:0];
  assign unused_addr = ^SRAM_ADDR[17:AW];
  assign is_write    = ~SRAM_CE_N & ~SRAM_WE_N;
  assign is_read     = ~SRAM_CE_N &  SRAM_WE_N & ~SRAM_OE_N;

  always_comb begin
    pipe_d[0] = '{valid: is_read, idx: idx, lb_n: SRAM_LB_N, ub_n: SRAM_UB_N};
    for (int i = 1; i < READ_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    // The array is read as a request leaves the last address stage, so any write
    // landing on an earlier edge is visible and one on this same edge is not.
    out_valid_d = pipe_q[LAST].valid;
    out_data_d  = mem[pipe_q[LAST].idx];
    out_lb_n_d  = pipe_q[LAST].lb_n;
    out_ub_n_d  = pipe_q[LAST].ub_n;
    wr_count_d  = wr_count_q + {15'd0, is_write};
    rd_count_d  = rd_count_q + {15'd0, is_read};
    proto_err_d = proto_err_q | (is_write & ~SRAM_OE_N);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < READ_LAT; i++) begin
        pipe_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lb_n_q  <= 1'b1;
      out_ub_n_q  <= 1'b1;
      wr_count_q  <= '0;
      rd_count_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < READ_LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_lb_n_q  <= out_lb_n_d;
      out_ub_n_q  <= out_ub_n_d;
      wr_count_q  <= wr_count_d;
      rd_count_q  <= rd_count_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Array has no reset; writes are suppressed on reset edges.
  always_ff @(posedge clk) begin
    if (rst && is_write) begin
      if (!SRAM_LB_N) mem[idx][7:0]  <= SRAM_DQ[7:0];
      if (!SRAM_UB_N) mem[idx][15:8] <= SRAM_DQ[15:8];
    end
  end

  // Drive follows the live strobes so a falling WE_N frees the bus immediately.
  assign drive_lo = out_valid_q & is_read & ~out_lb_n_q;
  assign drive_hi = out_valid_q & is_read & ~out_ub_n_q;

  assign SRAM_DQ[7:0]  = drive_lo ? out_data_q[7:0]  : 8'hzz;
  assign SRAM_DQ[15:8] = drive_hi ? out_data_q[15:8] : 8'hzz;

  assign wr_count  = wr_count_q;
  assign rd_count  = rd_count_q;
  assign proto_err = proto_err_q;

endmodule
`default_nettype wire
